seg_display_arbiter: RTL and testbench

- Shares the 8-digit seven-segment display between C_NUM_REQ requesters. Examples: PC monitor, register probe, debug counter, CPU MMIO.
- Grants the display round-robin. Each grant is held for a minimum on-screen time, C_HOLD_CYCLES.
- Registers the winner's 32-bit word onto DISP_DATA, which feeds the display driver's DATA input.
- Sits between the debug/MMIO sources and the display driver, in the CLK domain.

---
 rtl/seg_display_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter
// Brief    : Round-robin owner selection for the shared 8-digit display, with a
//            minimum on-screen hold per grant and a registered data mux.
//            Optional macro SEG_ARB_PREEMPT_EN makes requester 0 a preempting,
//            non-yielding priority source.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
    parameter int C_NUM_REQ     = 4,
    parameter int C_HOLD_CYCLES = 100000000,
    parameter int C_IDX_W       = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [C_NUM_REQ-1:0]     REQ,
    input  logic [32*C_NUM_REQ-1:0]  REQ_DATA,
    output logic [C_NUM_REQ-1:0]     GNT,
    output logic [31:0]              DISP_DATA,
    output logic [C_IDX_W-1:0]       DISP_OWNER,
    output logic                     DISP_VALID,
    output logic                     SWITCH_PULSE
);

    localparam logic [31:0] C_HOLD_LOAD = 32'(C_HOLD_CYCLES - 1);

`ifdef SEG_ARB_PREEMPT_EN
    localparam bit C_PREEMPT = 1'b1;
`else
    localparam bit C_PREEMPT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_OPEN = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [C_NUM_REQ-1:0]   gnt, gnt_nxt;
    logic [C_IDX_W-1:0]     owner, owner_nxt;
    logic [C_IDX_W-1:0]     ptr, ptr_nxt;
    logic [31:0]            cnt, cnt_nxt;
    logic [31:0]            disp_data;
    logic [31:0]            owner_data;
    logic                   disp_valid;
    logic                   switch_pulse;

    logic                   owner_req;
    logic [C_NUM_REQ-1:0]   others;
    logic                   preempt_hit;
    logic                   sticky_zero;
    logic                   do_pick;
    logic                   do_preempt;
    logic [C_NUM_REQ-1:0]   pick_mask;
    logic [C_IDX_W-1:0]     pick_idx;

    function automatic logic [C_IDX_W-1:0] lowest_set(input logic [C_NUM_REQ-1:0] v);
        logic [C_IDX_W-1:0] idx;
        idx = '0;
        for (int i = C_NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) idx = C_IDX_W'(i);
        end
        return idx;
    endfunction

    // First set bit at or above the pointer; otherwise wrap to the lowest set bit.
    function automatic logic [C_IDX_W-1:0] rr_pick(input logic [C_NUM_REQ-1:0] m,
                                                   input logic [C_IDX_W-1:0]   p);
        logic [C_NUM_REQ-1:0] upper;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            upper[i] = m[i] && (C_IDX_W'(i) >= p);
        end
        return (|upper) ? lowest_set(upper) : lowest_set(m);
    endfunction

    function automatic logic [C_NUM_REQ-1:0] onehot(input logic [C_IDX_W-1:0] k);
        logic [C_NUM_REQ-1:0] oh;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            oh[i] = (C_IDX_W'(i) == k);
        end
        return oh;
    endfunction

    function automatic logic [C_IDX_W-1:0] next_ptr(input logic [C_IDX_W-1:0] k);
        return (k == C_IDX_W'(C_NUM_REQ - 1)) ? '0 : k + C_IDX_W'(1);
    endfunction

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (gnt[i]) owner_data = REQ_DATA[32*i +: 32];
        end
    end

    assign owner_req   = |(REQ & gnt);
    assign others      = REQ & ~gnt;
    assign preempt_hit = C_PREEMPT && REQ[0] && !gnt[0];
    assign sticky_zero = C_PREEMPT && gnt[0];

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        owner_nxt  = owner;
        ptr_nxt    = ptr;
        cnt_nxt    = cnt;
        do_pick    = 1'b0;
        do_preempt = 1'b0;
        pick_mask  = '0;

        unique case (state)
            S_IDLE: begin
                if (preempt_hit) begin
                    do_preempt = 1'b1;
                end else if (|REQ) begin
                    do_pick   = 1'b1;
                    pick_mask = REQ;
                end
            end
            S_HOLD, S_OPEN: begin
                if (preempt_hit) begin
                    do_preempt = 1'b1;
                end else if (!owner_req) begin
                    // Release wins over expiry; the owner is excluded from the re-pick.
                    if (|others) begin
                        do_pick   = 1'b1;
                        pick_mask = others;
                    end else begin
                        state_nxt = S_IDLE;
                        gnt_nxt   = '0;
                    end
                end else if (state == S_HOLD && cnt != '0) begin
                    cnt_nxt = cnt - 32'd1;
                end else if ((|others) && !sticky_zero) begin
                    // Hand over directly so contended grants last exactly the hold time.
                    do_pick   = 1'b1;
                    pick_mask = others;
                end else begin
                    state_nxt = S_OPEN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
            end
        endcase

        pick_idx = rr_pick(pick_mask, ptr);

        if (do_preempt) begin
            // Preemptive grants leave the pointer untouched so order resumes afterwards.
            gnt_nxt   = onehot('0);
            owner_nxt = '0;
            cnt_nxt   = C_HOLD_LOAD;
            state_nxt = S_HOLD;
        end else if (do_pick) begin
            gnt_nxt   = onehot(pick_idx);
            owner_nxt = pick_idx;
            ptr_nxt   = next_ptr(pick_idx);
            cnt_nxt   = C_HOLD_LOAD;
            state_nxt = S_HOLD;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= S_IDLE;
            gnt          <= '0;
            owner        <= '0;
            ptr          <= '0;
            cnt          <= '0;
            disp_data    <= '0;
            disp_valid   <= 1'b0;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            gnt          <= gnt_nxt;
            owner        <= owner_nxt;
            ptr          <= ptr_nxt;
            cnt          <= cnt_nxt;
            disp_valid   <= |gnt_nxt;
            switch_pulse <= (|gnt_nxt) && (gnt_nxt != gnt);
            if (|gnt) disp_data <= owner_data;
        end
    end

    assign GNT          = gnt;
    assign DISP_DATA    = disp_data;
    assign DISP_OWNER   = owner;
    assign DISP_VALID   = disp_valid;
    assign SWITCH_PULSE = switch_pulse;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_arbiter
// Brief    : Directed self-checking bench for seg_display_arbiter (4 requesters,
//            hold of 4 cycles); covers SEG_ARB_PREEMPT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int IW   = 3;

    logic            CLK;
    logic            RESET;
    logic [N-1:0]    REQ;
    logic [32*N-1:0] REQ_DATA;
    logic [N-1:0]    GNT;
    logic [31:0]     DISP_DATA;
    logic [IW-1:0]   DISP_OWNER;
    logic            DISP_VALID;
    logic            SWITCH_PULSE;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] slot [N];

    seg_display_arbiter #(
        .C_NUM_REQ    (N),
        .C_HOLD_CYCLES(HOLD),
        .C_IDX_W      (IW)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ         (REQ),
        .REQ_DATA    (REQ_DATA),
        .GNT         (GNT),
        .DISP_DATA   (DISP_DATA),
        .DISP_OWNER  (DISP_OWNER),
        .DISP_VALID  (DISP_VALID),
        .SWITCH_PULSE(SWITCH_PULSE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] g, input logic [31:0] d,
                           input logic [IW-1:0] o, input logic v, input logic p);
        chk({tag, "_gnt"},   32'(GNT),          32'(g));
        chk({tag, "_data"},  DISP_DATA,         d);
        chk({tag, "_owner"}, 32'(DISP_OWNER),   32'(o));
        chk({tag, "_valid"}, 32'(DISP_VALID),   32'(v));
        chk({tag, "_pulse"}, 32'(SWITCH_PULSE), 32'(p));
    endtask

    initial begin
        slot[0] = 32'h00000A00;
        slot[1] = 32'hDEADBEEF;
        slot[2] = 32'h22222222;
        slot[3] = 32'h33333333;
        RESET    = 1'b1;
        REQ      = '0;
        REQ_DATA = {slot[3], slot[2], slot[1], slot[0]};
        tick();
        tick();
        chk_all("rst", 4'b0000, 32'h0, 3'd0, 1'b0, 1'b0);
        RESET = 1'b0;
        tick();
        chk_all("idle", 4'b0000, 32'h0, 3'd0, 1'b0, 1'b0);

        // Single requester; pointer ends at 2.
        REQ = 4'b0010;
        tick();
        chk_all("single_grant", 4'b0010, 32'h0, 3'd1, 1'b1, 1'b1);
        tick();
        chk_all("single_data", 4'b0010, 32'hDEADBEEF, 3'd1, 1'b1, 1'b0);
        repeat (6) tick();
        chk_all("single_held", 4'b0010, 32'hDEADBEEF, 3'd1, 1'b1, 1'b0);
        REQ = 4'b0000;
        tick();
        chk_all("single_idle", 4'b0000, 32'hDEADBEEF, 3'd1, 1'b0, 1'b0);

        // Early release of owner 2 one cycle into HOLD; pointer ends at 1.
        REQ = 4'b0101;
        tick();
        chk_all("early_grant2", 4'b0100, 32'hDEADBEEF, 3'd2, 1'b1, 1'b1);
        REQ = 4'b0001;
        tick();
        chk_all("early_move0", 4'b0001, 32'h22222222, 3'd0, 1'b1, 1'b1);
        REQ = 4'b0000;
        tick();
        chk_all("early_idle", 4'b0000, 32'h00000A00, 3'd0, 1'b0, 1'b0);
        tick();
        chk_all("early_retain", 4'b0000, 32'h00000A00, 3'd0, 1'b0, 1'b0);

        // Owner 1 drops REQ in its counter==0 cycle while 3 waits.
        REQ = 4'b0010;
        tick();
        chk("coin_grant1", 32'(GNT), 32'h2);
        REQ = 4'b1010;
        repeat (3) tick();
        chk("coin_last_hold", 32'(GNT), 32'h2);
        REQ = 4'b1000;
        tick();
        chk("coin_gnt3", 32'(GNT), 32'h8);
        chk("coin_pulse", 32'(SWITCH_PULSE), 32'h1);
        REQ = 4'b1010;
        repeat (3) tick();
        chk("coin_3_still", 32'(GNT), 32'h8);
        tick();
        chk("coin_1_after3", 32'(GNT), 32'h2);
        chk("coin_1_pulse", 32'(SWITCH_PULSE), 32'h1);
        REQ = 4'b0000;
        tick();
        chk("coin_idle", 32'(DISP_VALID), 32'h0);

        // Asynchronous reset between edges during a hold.
        REQ = 4'b1111;
        tick();
        tick();
        chk("arst_pre_valid", 32'(DISP_VALID), 32'h1);
        #2;
        RESET = 1'b1;
        #1;
        chk_all("arst_now", 4'b0000, 32'h0, 3'd0, 1'b0, 1'b0);
        #2;
        RESET = 1'b0;
        tick();
        chk_all("arst_restart", 4'b0001, 32'h0, 3'd0, 1'b1, 1'b1);

`ifndef SEG_ARB_PREEMPT_EN
        // Steady contention: every grant lasts exactly HOLD cycles, no gaps.
        for (int n = 1; n <= 4 * HOLD; n++) begin
            tick();
            chk($sformatf("rr_gnt%0d", n), 32'(GNT), 32'(4'b0001 << ((n / HOLD) % N)));
            chk($sformatf("rr_pulse%0d", n), 32'(SWITCH_PULSE), 32'((n % HOLD) == 0));
            chk($sformatf("rr_data%0d", n), DISP_DATA, slot[((n - 1) / HOLD) % N]);
        end
`else
        // Requester 0 never yields on expiry.
        for (int n = 0; n < 20; n++) begin
            tick();
            chk($sformatf("pre_sticky%0d", n), 32'(GNT), 32'h1);
        end
        REQ = 4'b0000;
        tick();
        chk("pre_idle", 32'(GNT), 32'h0);
        REQ = 4'b0100;
        tick();
        chk("pre_grant2", 32'(GNT), 32'h4);
        REQ = 4'b0101;
        tick();
        chk("pre_take0", 32'(GNT), 32'h1);
        chk("pre_take0_pulse", 32'(SWITCH_PULSE), 32'h1);
        REQ = 4'b1111;
        for (int n = 0; n < 20; n++) begin
            tick();
            chk($sformatf("pre_hold%0d", n), 32'(GNT), 32'h1);
        end
        REQ = 4'b1110;
        tick();
        chk("pre_resume3", 32'(GNT), 32'h8);
        chk("pre_resume_owner", 32'(DISP_OWNER), 32'h3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
